// File: rtl/vga_pkg.sv
// Shared display and framebuffer constants for the VGA scan-out path.
// The timing generator and the framebuffer arbiter both import these.
package vga_pkg;

    localparam int unsigned H_DISPLAY  = 640;
    localparam int unsigned V_DISPLAY  = 480;
    localparam int unsigned SCALE_LOG2 = 2;

    localparam int unsigned FB_W     = H_DISPLAY >> SCALE_LOG2;
    localparam int unsigned FB_H     = V_DISPLAY >> SCALE_LOG2;
    localparam int unsigned FB_DEPTH = FB_W * FB_H;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned COLOR_W  = 8;

    typedef enum logic {
        IDLE,
        CLEAR
    } arb_state_t;

endpackage

// File: rtl/vga_fb_addr.sv
// Maps a screen pixel (x,y) to its 4x4-block framebuffer cell address and
// flags whether the pixel is visible and whether this cycle is a scan-out slot.
module vga_fb_addr
    import vga_pkg::*;
#(
    parameter int unsigned ADDR_W = 15
) (
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic              in_active,
    output logic              slot
);

    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;

    always_comb begin
        row       = ADDR_W'(y >> SCALE_LOG2);
        col       = ADDR_W'(x >> SCALE_LOG2);
        // row * 160 as row*128 + row*32
        addr      = (row << 7) + (row << 5) + col;
        in_active = (x < 10'(H_DISPLAY)) && (y < 10'(V_DISPLAY));
        slot      = in_active && (x[SCALE_LOG2-1:0] == '0);
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: guaranteed scan-out read slots, with the
// remaining cycles shared by a hardware clear engine and a valid/ready writer.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_W = 8,
    parameter int unsigned FB_W    = 160,
    parameter int unsigned FB_H    = 120,
    parameter int unsigned ADDR_W  = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    input  logic               clr_start,
    input  logic [COLOR_W-1:0] clr_color,
    output logic               clr_busy,
    output logic               clr_done,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic [COLOR_W-1:0] pixel,
    output logic               pixel_valid
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

    logic [ADDR_W-1:0]  scan_addr;
    logic               in_active;
    logic               slot;
    logic               free;

    arb_state_t         state;
    arb_state_t         state_next;
    logic [ADDR_W-1:0]  cnt;
    logic [ADDR_W-1:0]  cnt_next;
    logic [COLOR_W-1:0] fill_color;
    logic [COLOR_W-1:0] fill_color_next;

    logic [ADDR_W-1:0]  addr_d;
    logic               we_d;
    logic [COLOR_W-1:0] wdata_d;
    logic               done_d;

    logic [1:0]         slot_pipe;
    logic [2:0]         active_pipe;
    logic [COLOR_W-1:0] hold;

    vga_fb_addr #(
        .ADDR_W (ADDR_W)
    ) u_addr (
        .x         (x),
        .y         (y),
        .addr      (scan_addr),
        .in_active (in_active),
        .slot      (slot)
    );

    assign free = ~slot;

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        fill_color_next = fill_color;
        wr_ready        = 1'b0;
        addr_d          = scan_addr;
        we_d            = 1'b0;
        wdata_d         = '0;
        done_d          = 1'b0;

        case (state)
            IDLE: begin
                // A clear request takes the cycle even when a write is pending.
                if (clr_start) begin
                    state_next      = CLEAR;
                    cnt_next        = '0;
                    fill_color_next = clr_color;
                end else begin
                    wr_ready = free;
                    if (wr_valid && free) begin
                        addr_d  = wr_addr;
                        wdata_d = wr_data;
                        we_d    = (wr_addr <= LAST_ADDR);
                    end
                end
            end

            CLEAR: begin
                if (free) begin
                    addr_d  = cnt;
                    wdata_d = fill_color;
                    we_d    = 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state_next = IDLE;
                        done_d     = 1'b1;
                    end else begin
                        cnt_next = cnt + ADDR_W'(1);
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            fill_color  <= '0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            clr_done    <= 1'b0;
            slot_pipe   <= '0;
            active_pipe <= '0;
            hold        <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            fill_color  <= fill_color_next;
            mem_addr    <= addr_d;
            mem_we      <= we_d;
            mem_wdata   <= wdata_d;
            clr_done    <= done_d;
            slot_pipe   <= {slot_pipe[0], slot};
            active_pipe <= {active_pipe[1:0], in_active};
            // Read data returns two cycles after the slot decision.
            if (slot_pipe[1]) begin
                hold <= mem_rdata;
            end
        end
    end

    assign clr_busy    = (state == CLEAR);
    assign pixel_valid = active_pipe[2];
    assign pixel       = pixel_valid ? hold : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: expected RAM writes and pixel values
// are queued as stimulus is driven and retired as the DUT produces them.
module tb_vga_fb_arbiter;

    localparam int DEPTH = 19200;

    typedef struct packed {
        logic [14:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        clr_start;
    logic [7:0]  clr_color;
    logic        clr_busy;
    logic        clr_done;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  pixel;
    logic        pixel_valid;

    int tests = 0;
    int fails = 0;

    wr_t        wq[$];
    logic [7:0] pq[$];
    logic [7:0] rom [0:DEPTH-1];

    vga_fb_arbiter #(
        .COLOR_W (8),
        .FB_W    (160),
        .FB_H    (120),
        .ADDR_W  (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clr_start   (clr_start),
        .clr_color   (clr_color),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .pixel       (pixel),
        .pixel_valid (pixel_valid)
    );

    always #20 clk = ~clk;

    // Synchronous read-only RAM model; writes are checked by the scoreboard.
    always @(posedge clk) begin
        mem_rdata <= (mem_addr < 15'(DEPTH)) ? rom[mem_addr] : 8'h00;
    end

    always @(posedge clk) begin : write_monitor
        wr_t e;
        #1;
        if (mem_we === 1'b1) begin
            tests++;
            if (wq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%02h, expected no write",
                         mem_addr, mem_wdata);
            end else begin
                e = wq.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    fails++;
                    $display("FAIL write_data: got addr=%0d data=0x%02h, expected addr=%0d data=0x%02h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        x = 10'd0;
        y = 10'd0;
        tick();
        tick();
        tests++; if (mem_addr !== 15'd0)  begin fails++; $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr); end
        tests++; if (mem_we !== 1'b0)     begin fails++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        tests++; if (mem_wdata !== 8'h00) begin fails++; $display("FAIL reset_mem_wdata: got 0x%02h expected 0x00", mem_wdata); end
        tests++; if (pixel !== 8'h00)     begin fails++; $display("FAIL reset_pixel: got 0x%02h expected 0x00", pixel); end
        tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL reset_pixel_valid: got %b expected 0", pixel_valid); end
        tests++; if (clr_busy !== 1'b0)   begin fails++; $display("FAIL reset_clr_busy: got %b expected 0", clr_busy); end
        tests++; if (clr_done !== 1'b0)   begin fails++; $display("FAIL reset_clr_done: got %b expected 0", clr_done); end
        tests++; if (dut.state !== vga_pkg::IDLE) begin fails++; $display("FAIL reset_state: got %0d expected IDLE", dut.state); end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            x = 10'(4 * k);
            tick();
            tests++;
            if (mem_addr !== 15'(k) || mem_we !== 1'b0) begin
                fails++;
                $display("FAIL scan_addr_row0: got addr=%0d we=%b expected addr=%0d we=0", mem_addr, mem_we, k);
            end
        end
    endtask

    task automatic test_scan_read();
        logic [7:0] e;
        rom[482] = 8'h5A;
        rom[483] = 8'hC3;
        rom[639] = 8'hEE;
        y = 10'd12;
        for (int i = 8; i <= 18; i++) begin
            x = 10'(i);
            if (i % 4 == 0) begin
                for (int r = 0; r < 4; r++) pq.push_back(rom[3 * 160 + i / 4]);
            end
            #1;
            if (i == 9) begin
                tests++;
                if (mem_addr !== 15'd482 || mem_we !== 1'b0) begin
                    fails++;
                    $display("FAIL scan_read_addr: got addr=%0d we=%b expected addr=482 we=0", mem_addr, mem_we);
                end
            end
            if (i >= 11) begin
                e = pq.pop_front();
                tests++;
                if (pixel !== e || pixel_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL scan_pixel x=%0d: got pixel=0x%02h valid=%b expected pixel=0x%02h valid=1",
                             i, pixel, pixel_valid, e);
                end
            end
            tick();
        end
        pq.delete();
        for (int i = 636; i <= 645; i++) begin
            x = 10'(i);
            #1;
            if (i >= 639 && i <= 642) begin
                tests++;
                if (pixel !== 8'hEE || pixel_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL edge_pixel x=%0d: got pixel=0x%02h valid=%b expected pixel=0xee valid=1",
                             i, pixel, pixel_valid);
                end
            end
            if (i >= 643) begin
                tests++;
                if (pixel !== 8'h00 || pixel_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL blank_pixel x=%0d: got pixel=0x%02h valid=%b expected pixel=0x00 valid=0",
                             i, pixel, pixel_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_writer_contention();
        y = 10'd0;
        x = 10'd0;
        wr_valid = 1'b1;
        wr_addr = 15'd100;
        wr_data = 8'h33;
        #1;
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL contention_ready_x0: got %b expected 0", wr_ready); end
        tick();
        x = 10'd1;
        #1;
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL contention_ready_x1: got %b expected 1", wr_ready); end
        wq.push_back(wr_t'{addr: 15'd100, data: 8'h33});
        tick();
        wr_valid = 1'b0;
        x = 10'd2;
        tick();
        x = 10'd3;
        tick();
        tests++; if (wq.size() != 0) begin fails++; $display("FAIL contention_pending: got %0d writes outstanding expected 0", wq.size()); end
    endtask

    task automatic test_back_to_back();
        logic [14:0] a = 15'd200;
        logic [7:0]  d = 8'h40;
        logic        exp_ready;
        int          pushed = 0;
        y = 10'd4;
        wr_valid = 1'b1;
        wr_addr = a;
        wr_data = d;
        for (int i = 0; i < 12; i++) begin
            x = 10'(i);
            #1;
            exp_ready = (i % 4 != 0);
            tests++;
            if (wr_ready !== exp_ready) begin
                fails++;
                $display("FAIL b2b_ready x=%0d: got %b expected %b", i, wr_ready, exp_ready);
            end
            if (exp_ready) begin
                wq.push_back(wr_t'{addr: a, data: d});
                pushed++;
            end
            tick();
            if (exp_ready) begin
                a = a + 15'd1;
                d = d + 8'd1;
                wr_addr = a;
                wr_data = d;
            end
        end
        wr_valid = 1'b0;
        tick();
        tests++;
        if (wq.size() != 0 || pushed != 9) begin
            fails++;
            $display("FAIL b2b_count: got %0d outstanding of %0d expected 0 of 9", wq.size(), pushed);
        end
    endtask

    task automatic test_out_of_range();
        y = 10'd500;
        x = 10'd0;
        wr_valid = 1'b1;
        wr_addr = 15'd19200;
        wr_data = 8'h11;
        #1;
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL oor_ready: got %b expected 1", wr_ready); end
        tick();
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL oor_we: got %b expected 0", mem_we); end
        wr_addr = 15'd19199;
        wr_data = 8'h22;
        wq.push_back(wr_t'{addr: 15'd19199, data: 8'h22});
        #1;
        tick();
        wr_valid = 1'b0;
        tick();
        tests++; if (wq.size() != 0) begin fails++; $display("FAIL last_addr_write: got %0d outstanding expected 0", wq.size()); end
    endtask

    task automatic test_clear();
        int done_cnt = 0;
        int done_at = -1;
        int bad_ready = 0;
        int bad_busy = 0;
        int bad_gap = 0;
        y = 10'd500;
        x = 10'd0;
        for (int i = 0; i < DEPTH; i++) wq.push_back(wr_t'{addr: 15'(i), data: 8'h07});
        wr_valid = 1'b1;
        wr_addr = 15'd5;
        wr_data = 8'hAA;
        clr_start = 1'b1;
        clr_color = 8'h07;
        #1;
        tests++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL clear_wins_ready: got %b expected 0", wr_ready); end
        tick();
        clr_start = 1'b0;
        clr_color = 8'hFF;
        tests++; if (clr_busy !== 1'b1) begin fails++; $display("FAIL clear_busy_rise: got %b expected 1", clr_busy); end
        for (int j = 0; j < 19300; j++) begin
            x = 10'(j % 800);
            #1;
            if (clr_done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_at = j;
                    wr_valid = 1'b0;
                    tests++;
                    if (clr_busy !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 15'd19199) begin
                        fails++;
                        $display("FAIL clear_done_cycle: got busy=%b we=%b addr=%0d expected busy=0 we=1 addr=19199",
                                 clr_busy, mem_we, mem_addr);
                    end
                end
            end else if (done_cnt == 0) begin
                if (wr_ready !== 1'b0) bad_ready++;
                if (clr_busy !== 1'b1) bad_busy++;
                if (j >= 1 && mem_we !== 1'b1) bad_gap++;
            end
            clr_start = (j == 100);
            if (j == 100) clr_color = 8'h99;
            tick();
            if (done_cnt > 0 && j > done_at + 2) break;
        end
        clr_start = 1'b0;
        wr_valid = 1'b0;
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL clear_done_count: got %0d pulses expected 1", done_cnt); end
        tests++; if (done_at != 19200) begin fails++; $display("FAIL clear_duration: got done at cycle %0d expected 19200", done_at); end
        tests++; if (bad_ready != 0) begin fails++; $display("FAIL clear_ready_low: got %0d cycles with wr_ready=1 expected 0", bad_ready); end
        tests++; if (bad_busy != 0) begin fails++; $display("FAIL clear_busy_high: got %0d cycles with clr_busy=0 expected 0", bad_busy); end
        tests++; if (bad_gap != 0) begin fails++; $display("FAIL clear_consecutive: got %0d idle cycles expected 0", bad_gap); end
        tests++; if (wq.size() != 0) begin fails++; $display("FAIL clear_coverage: got %0d writes missing expected 0", wq.size()); end
        wq.delete();
    endtask

    task automatic test_reset_mid_clear();
        int done_seen = 0;
        y = 10'd500;
        x = 10'd0;
        wr_valid = 1'b0;
        for (int i = 0; i < 50; i++) wq.push_back(wr_t'{addr: 15'(i), data: 8'h07});
        clr_start = 1'b1;
        clr_color = 8'h07;
        tick();
        clr_start = 1'b0;
        for (int n = 0; n < 50; n++) tick();
        reset = 1'b1;
        tick();
        tests++;
        if (clr_busy !== 1'b0 || mem_we !== 1'b0 || clr_done !== 1'b0) begin
            fails++;
            $display("FAIL midclear_reset: got busy=%b we=%b done=%b expected 0 0 0", clr_busy, mem_we, clr_done);
        end
        tick();
        reset = 1'b0;
        tests++; if (wq.size() != 0) begin fails++; $display("FAIL midclear_writes: got %0d missing expected 0", wq.size()); end
        for (int n = 0; n < 4; n++) begin
            tick();
            if (clr_done === 1'b1) done_seen++;
        end
        tests++; if (done_seen != 0) begin fails++; $display("FAIL midclear_no_done: got %0d pulses expected 0", done_seen); end
        x = 10'd1;
        wr_valid = 1'b1;
        wr_addr = 15'd7;
        wr_data = 8'h42;
        #1;
        tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b expected 1", wr_ready); end
        wq.push_back(wr_t'{addr: 15'd7, data: 8'h42});
        tick();
        wr_valid = 1'b0;
        tick();
        tests++; if (wq.size() != 0) begin fails++; $display("FAIL post_reset_write: got %0d outstanding expected 0", wq.size()); end
    endtask

    initial begin
        reset = 1'b1;
        x = 10'd0;
        y = 10'd0;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        clr_start = 1'b0;
        clr_color = '0;
        for (int i = 0; i < DEPTH; i++) rom[i] = 8'h00;

        test_reset();
        test_scan_read();
        test_writer_contention();
        test_back_to_back();
        test_out_of_range();
        test_clear();
        test_reset_mid_clear();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
